// File: rtl/udma_i2c_cmd_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : udma_i2c_cmd_arbiter_if
// Brief   : Command-stream bundle between N_REQ command sources, the
//           udma_i2c_cmd_arbiter and udma_i2c_control. Signal names keep
//           their direction suffix as seen from the arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface udma_i2c_cmd_arbiter_if #(
  parameter int N_REQ     = 2,
  parameter int CMD_WIDTH = 32
);

  // Requester side: slice i of req_cmd_i is [i*CMD_WIDTH +: CMD_WIDTH]
  logic [N_REQ*CMD_WIDTH-1:0] req_cmd_i;
  logic [N_REQ-1:0]           req_valid_i;
  logic [N_REQ-1:0]           req_ready_o;

  // Controller side
  logic [CMD_WIDTH-1:0]       cmd_o;
  logic                       cmd_valid_o;
  logic                       cmd_ready_i;

  // Status
  logic [N_REQ-1:0]           grant_o;
  logic                       busy_o;
  logic                       timeout_o;

  // Environment side: drives requests and controller ready, observes the rest
  modport master (
    output req_cmd_i, req_valid_i, cmd_ready_i,
    input  req_ready_o, cmd_o, cmd_valid_o, grant_o, busy_o, timeout_o
  );

  // Arbiter side
  modport slave (
    input  req_cmd_i, req_valid_i, cmd_ready_i,
    output req_ready_o, cmd_o, cmd_valid_o, grant_o, busy_o, timeout_o
  );

endinterface

`default_nettype wire

// File: rtl/udma_i2c_cmd_arbiter.sv
//------------------------------------------------------------------------------
// Module  : udma_i2c_cmd_arbiter
// Brief   : Round-robin arbiter sharing the I2C command stream between N_REQ
//           command sources. The grant is locked from the first command of a
//           source until one of its STOP commands is accepted, so transactions
//           never interleave. Optional stall watchdog enabled by defining
//           UDMA_I2C_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module udma_i2c_cmd_arbiter #(
  parameter int          N_REQ          = 2,
  parameter int          CMD_WIDTH      = 32,
  parameter logic [3:0]  CMD_STOP       = 4'h2,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  wire logic            clk_i,
  input  wire logic            rstn_i,
  input  wire logic            clr_i,
  udma_i2c_cmd_arbiter_if.slave bus
);

  localparam int               PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(N_REQ - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;
  logic [PTR_W-1:0]     last_ptr_q, last_ptr_d;
  logic                 timeout_q, timeout_d;

  logic                 locked;
  logic [PTR_W-1:0]     sel_idx;
  logic                 sel_found;
  logic [CMD_WIDTH-1:0] gnt_cmd;
  logic                 gnt_valid;
  logic                 out_valid;
  logic                 hs;
  logic                 stop_hs;
  logic                 wdog_hit;

  assign locked = (state_q == ST_LOCKED);

  // Ring scan starting just after the last releasing requester; first valid wins
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      int               cand;
      logic [PTR_W-1:0] cand_idx;
      cand = int'(last_ptr_q) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = PTR_W'(cand);
      if (!sel_found && bus.req_valid_i[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // One-hot mux of the granted requester; all zeros while nothing is granted
  always_comb begin
    gnt_cmd   = '0;
    gnt_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        gnt_cmd   = bus.req_cmd_i[i*CMD_WIDTH +: CMD_WIDTH];
        gnt_valid = bus.req_valid_i[i];
      end
    end
  end

  // Zero-latency pass-through while locked; clr blocks any handshake
  assign out_valid       = locked & ~clr_i & gnt_valid;
  assign hs              = out_valid & bus.cmd_ready_i;
  assign stop_hs         = hs & (gnt_cmd[CMD_WIDTH-1 -: 4] == CMD_STOP);

  assign bus.cmd_o       = gnt_cmd;
  assign bus.cmd_valid_o = out_valid;
  assign bus.req_ready_o = (locked && !clr_i && bus.cmd_ready_i) ? grant_q : '0;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = locked;
  assign bus.timeout_o   = timeout_q;

`ifdef UDMA_I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;

  // Count locked cycles with no command offered; a stalled controller
  // (valid without ready) holds the count rather than advancing it
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_hit   = 1'b0;
    if (!locked || clr_i || hs) begin
      wdog_cnt_d = '0;
    end else if (!out_valid) begin
      if (wdog_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        wdog_hit   = 1'b1;
        wdog_cnt_d = '0;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 1'b1;
      end
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign wdog_hit           = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state: clr overrides everything; release on accepted STOP or watchdog
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    last_ptr_d = last_ptr_q;
    timeout_d  = 1'b0;
    if (clr_i) begin
      state_d    = ST_IDLE;
      grant_d    = '0;
      gidx_d     = '0;
      last_ptr_d = LAST_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            state_d          = ST_LOCKED;
            grant_d          = '0;
            grant_d[sel_idx] = 1'b1;
            gidx_d           = sel_idx;
          end
        end
        ST_LOCKED: begin
          if (stop_hs || wdog_hit) begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            last_ptr_d = gidx_q;
            timeout_d  = wdog_hit;
          end
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      endcase
    end
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_ptr_q <= LAST_RST;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_ptr_q <= last_ptr_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

`default_nettype wire
